// File: rtl/softmc_pkg.sv
// Shared definitions for the instruction-sequence ingress block.
// Holds the opcode field position, the default end-of-sequence opcode and
// padding instruction, the loader FSM state type and a small helper that
// extracts the opcode from a 32-bit instruction word.
package softmc_pkg;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;

   localparam logic [3:0]  END_OP_DEFAULT    = 4'hF;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_APP,
      LOAD_MAINT,
      PAD
   } iseq_state_t;

   function automatic logic [3:0] opcode_of(input logic [31:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/iseq_ingress_if.sv
// Bus bundle between the ingress block and its neighbours.
// master: the side that offers instructions, reports dispatcher status and
//         pops the lanes (host, maintenance unit, dispatcher).
// slave : the ingress block itself.
// Signals:
//   app_en/app_instr/app_ack       host instruction offer and acceptance
//   maint_en/maint_instr/maint_ack maintenance instruction offer and acceptance
//   disp_ready                     dispatcher idle
//   iseq_start                     one-cycle start of the oldest committed sequence
//   lane_rd_en/lane_data/lane_empty per-lane pop, head word, empty flag
//   iq_full                        any lane full
//   pending_seqs                   committed sequences not yet started
interface iseq_ingress_if #(
   parameter int NUM_LANES = 2,
   parameter int MAX_SEQS  = 2
);
   localparam int PEND_W = $clog2(MAX_SEQS + 1);

   logic                    app_en;
   logic [31:0]             app_instr;
   logic                    app_ack;
   logic                    maint_en;
   logic [31:0]             maint_instr;
   logic                    maint_ack;
   logic                    disp_ready;
   logic                    iseq_start;
   logic [NUM_LANES-1:0]    lane_rd_en;
   logic [32*NUM_LANES-1:0] lane_data;
   logic [NUM_LANES-1:0]    lane_empty;
   logic                    iq_full;
   logic [PEND_W-1:0]       pending_seqs;

   modport master (
      output app_en, app_instr, maint_en, maint_instr, disp_ready, lane_rd_en,
      input  app_ack, maint_ack, iseq_start, lane_data, lane_empty, iq_full, pending_seqs
   );

   modport slave (
      input  app_en, app_instr, maint_en, maint_instr, disp_ready, lane_rd_en,
      output app_ack, maint_ack, iseq_start, lane_data, lane_empty, iq_full, pending_seqs
   );

endinterface

// File: rtl/iseq_ingress_lane_fifo.sv
// lane_fifo: first-word-fall-through FIFO holding one instruction lane.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   wr_en, wr_data  push (ignored while full)
//   rd_en           pop (ignored while empty)
//   rd_data         head word, forced to zero while empty
//   full, empty     status flags, both taken before any same-cycle pop
module lane_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_write;
   logic             do_read;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign do_write = wr_en && !full;
   assign do_read  = rd_en && !empty;
   assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_read)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is not reset; stale words are hidden by the empty flag
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/iseq_ingress.sv
// iseq_ingress: collects instruction sequences from the host (app) or the
// maintenance unit, spreads them round-robin over NUM_LANES lane FIFOs,
// pads each sequence with NOPs up to a full lane row, counts committed
// sequences and starts the dispatcher once per idle period.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       iseq_ingress_if slave modport (offers, acks, dispatch, lanes)
module iseq_ingress
   import softmc_pkg::*;
#(
   parameter int          NUM_LANES  = 2,
   parameter int          FIFO_DEPTH = 64,
   parameter int          MAX_SEQS   = 2,
   parameter logic [3:0]  END_OP     = END_OP_DEFAULT,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   iseq_ingress_if.slave  bus
);
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int PW = $clog2(MAX_SEQS + 1);

   iseq_state_t             state;
   iseq_state_t             state_next;
   logic [LW-1:0]           wr_lane;
   logic [PW-1:0]           pending;
   logic                    armed;
   logic                    app_ack;
   logic                    maint_ack;
   logic                    wr_en;
   logic [31:0]             wr_data;
   logic                    commit;
   logic                    start;
   logic                    target_full;
   logic                    can_accept;
   logic                    last_lane;
   logic [NUM_LANES-1:0]    lane_wr;
   logic [NUM_LANES-1:0]    lane_full;
   logic [NUM_LANES-1:0]    lane_empty;
   logic [31:0]             lane_q [NUM_LANES];
   logic [32*NUM_LANES-1:0] lane_data_flat;

   // Full flag of the lane the next word will land in
   always_comb begin
      target_full = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (wr_lane == LW'(i)) target_full = lane_full[i];
      end
   end

   assign last_lane  = (wr_lane == LW'(NUM_LANES - 1));
   assign can_accept = !rst && !target_full && (pending < PW'(MAX_SEQS));
   assign start      = !rst && armed && bus.disp_ready && (pending != '0);

   // Loader state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Loader next state and write control. The source that wins the first
   // word owns the lanes until its END word has been padded to a full row;
   // a write into the last lane after END is the commit point.
   always_comb begin
      state_next = state;
      app_ack    = 1'b0;
      maint_ack  = 1'b0;
      wr_en      = 1'b0;
      wr_data    = NOP_INSTR;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.maint_en && can_accept) begin
               maint_ack  = 1'b1;
               state_next = LOAD_MAINT;
            end else if (bus.app_en && can_accept) begin
               app_ack    = 1'b1;
               state_next = LOAD_APP;
            end
         end
         LOAD_APP:   app_ack   = bus.app_en && can_accept;
         LOAD_MAINT: maint_ack = bus.maint_en && can_accept;
         PAD: begin
            if (!target_full) begin
               wr_en = 1'b1;
               if (last_lane) begin
                  commit     = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (app_ack || maint_ack) begin
         wr_en   = 1'b1;
         wr_data = maint_ack ? bus.maint_instr : bus.app_instr;
         if (opcode_of(wr_data) == END_OP) begin
            if (last_lane) begin
               commit     = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = PAD;
            end
         end
      end
   end

   // Round-robin lane pointer, advanced by every word written
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        wr_lane <= '0;
      else if (wr_en) wr_lane <= last_lane ? '0 : wr_lane + LW'(1);
   end

   // Committed-sequence count; a commit and a start together cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         case ({commit, start})
            2'b10:   pending <= pending + PW'(1);
            2'b01:   pending <= pending - PW'(1);
            default: pending <= pending;
         endcase
      end
   end

   // One start per dispatcher busy period: disarm on start, re-arm once the
   // dispatcher has been seen busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  armed <= 1'b1;
      else if (start)           armed <= 1'b0;
      else if (!bus.disp_ready) armed <= 1'b1;
   end

   // Steer the single write port to the selected lane
   always_comb begin
      lane_wr = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (wr_en && (wr_lane == LW'(i))) lane_wr[i] = 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_fifo #(
         .WIDTH (32),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (lane_wr[g]),
         .wr_data (wr_data),
         .rd_en   (bus.lane_rd_en[g]),
         .rd_data (lane_q[g]),
         .full    (lane_full[g]),
         .empty   (lane_empty[g])
      );
   end

   // Flatten lane heads, lane i at bits [32i+31:32i]
   always_comb begin
      lane_data_flat = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_data_flat[32*i +: 32] = lane_q[i];
      end
   end

   assign bus.app_ack      = app_ack;
   assign bus.maint_ack    = maint_ack;
   assign bus.iseq_start   = start;
   assign bus.lane_data    = lane_data_flat;
   assign bus.lane_empty   = lane_empty;
   assign bus.iq_full      = |lane_full;
   assign bus.pending_seqs = pending;

endmodule
